hamming_tx_serializer: RTL and testbench

HAMMING_TX_SERIALIZER -- requirements
Module: hamming_tx_serializer

---
 rtl/hamming_pkg.sv | 37 +++
 rtl/hamming_encoder.sv | 24 ++
 rtl/hamming_tx_serializer.sv | 160 ++++++++++++++++
 tb/tb_hamming_tx_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (7,4) transmit serializer.
// Holds the data/codeword widths, the parity bit positions, the
// serializer FSM state type and the error-injection mask helper.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CW_W   = 7;

    // Hamming positions are 1-based; codeword bit [k-1] carries position k.
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // One-hot flip mask for a 1-based Hamming position; position 0 or a
    // disabled injection yields an all-zero mask.
    function automatic logic [CW_W-1:0] inj_mask(input logic en, input logic [2:0] pos);
        logic [CW_W-1:0] mask;
        mask = 7'd0;
        if (en && (pos != 3'd0)) begin
            mask[pos - 3'd1] = 1'b1;
        end else begin
            mask = 7'd0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming_encoder.sv
// Purely combinational even-parity Hamming (7,4) encoder.
// Ports:
//   data_i     [3:0] data nibble d[3:0]
//   codeword_o [6:0] codeword, bit [k-1] = Hamming position k
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   codeword_o
);

    // Place data bits and compute the three even-parity bits.
    always_comb begin
        codeword_o             = 7'd0;
        codeword_o[D0_POS-1]   = data_i[0];
        codeword_o[D1_POS-1]   = data_i[1];
        codeword_o[D2_POS-1]   = data_i[2];
        codeword_o[D3_POS-1]   = data_i[3];
        codeword_o[P1_POS-1]   = data_i[0] ^ data_i[1] ^ data_i[3];
        codeword_o[P2_POS-1]   = data_i[0] ^ data_i[2] ^ data_i[3];
        codeword_o[P4_POS-1]   = data_i[1] ^ data_i[2] ^ data_i[3];
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming (7,4) transmit serializer with error injection.
// Accepts a nibble on a valid/ready handshake, encodes it (optionally
// flipping one Hamming position), presents the codeword in parallel and
// shifts it out LSB (position 1) first, then inserts GAP_CYCLES idle cycles.
// With GAP_CYCLES = 0 the next nibble may be accepted on the last bit of
// the current frame so frames stream back to back.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   nibble handshake; in_data, inj_en, inj_pos captured on transfer
//   codeword/code_valid last encoded codeword and its one-cycle update pulse
//   ser_out/ser_valid   serial bit stream and its qualifier
//   frame_start         marks position 1 of each frame
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              inj_en,
    input  logic [2:0]        inj_pos,
    output logic [CW_W-1:0]   codeword,
    output logic              code_valid,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start
);

    localparam int         GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [3:0] GAP_LAST   = GAP_LAST_I[3:0];
    localparam logic       NO_GAP     = (GAP_CYCLES == 0);

    ser_state_t      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      gap_q, gap_d;
    logic [CW_W-1:0] cw_q, cw_d;
    logic            cv_q, cv_d;
    logic            ready_q, ready_d;
    logic            sout_q, sout_d;
    logic            sval_q, sval_d;
    logic            fstart_q, fstart_d;
    logic [CW_W-1:0] enc_s;
    logic            xfer_s;

    hamming_encoder u_enc (
        .data_i     (in_data),
        .codeword_o (enc_s)
    );

    // in_ready is a register, so the handshake seen upstream is the same
    // value the FSM qualifies the transfer with.
    assign xfer_s = in_valid && ready_q;

    // Next-state logic; outputs are derived from the next state so they
    // can be registered without adding a cycle of latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cw_d    = cw_q;
        cv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    state_d = SHIFT;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == 3'd6) begin
                    cnt_d = 3'd0;
                    if (NO_GAP) begin
                        // Gapless mode: a transfer on the last bit restarts immediately.
                        state_d = xfer_s ? SHIFT : IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
                gap_d   = 4'd0;
            end
        endcase

        if (xfer_s) begin
            cw_d = enc_s ^ inj_mask(inj_en, inj_pos);
            cv_d = 1'b1;
        end else begin
            cw_d = cw_q;
        end
    end

    // Output decode from the next state, registered below.
    always_comb begin
        sval_d   = 1'b0;
        sout_d   = 1'b0;
        fstart_d = 1'b0;
        ready_d  = 1'b0;
        if (state_d == SHIFT) begin
            sval_d   = 1'b1;
            sout_d   = cw_d[cnt_d];
            fstart_d = (cnt_d == 3'd0);
            ready_d  = NO_GAP && (cnt_d == 3'd6);
        end else begin
            ready_d  = (state_d == IDLE);
        end
    end

    // State, counters and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            gap_q    <= 4'd0;
            cw_q     <= 7'd0;
            cv_q     <= 1'b0;
            ready_q  <= 1'b1;
            sout_q   <= 1'b0;
            sval_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            cw_q     <= cw_d;
            cv_q     <= cv_d;
            ready_q  <= ready_d;
            sout_q   <= sout_d;
            sval_q   <= sval_d;
            fstart_q <= fstart_d;
        end
    end

    assign in_ready    = ready_q;
    assign codeword    = cw_q;
    assign code_valid  = cv_q;
    assign ser_out     = sout_q;
    assign ser_valid   = sval_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed self-checking bench for hamming_tx_serializer.
// dut0 runs with GAP_CYCLES=0, dut3 with GAP_CYCLES=3; both share clk/rst.
module tb_hamming_tx_serializer;
    import hamming_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid0 = 1'b0, inj_en0 = 1'b0;
    logic [3:0] in_data0 = 4'd0;
    logic [2:0] inj_pos0 = 3'd0;
    logic       in_ready0, code_valid0, ser_out0, ser_valid0, frame_start0;
    logic [6:0] codeword0;

    logic       in_valid3 = 1'b0, inj_en3 = 1'b0;
    logic [3:0] in_data3 = 4'd0;
    logic [2:0] inj_pos3 = 3'd0;
    logic       in_ready3, code_valid3, ser_out3, ser_valid3, frame_start3;
    logic [6:0] codeword3;

    logic [3:0] ref_data = 4'd0;
    logic [6:0] ref_cw;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hamming_tx_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .inj_en(inj_en0), .inj_pos(inj_pos0),
        .codeword(codeword0), .code_valid(code_valid0), .ser_out(ser_out0),
        .ser_valid(ser_valid0), .frame_start(frame_start0)
    );

    hamming_tx_serializer #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .inj_en(inj_en3), .inj_pos(inj_pos3),
        .codeword(codeword3), .code_valid(code_valid3), .ser_out(ser_out3),
        .ser_valid(ser_valid3), .frame_start(frame_start3)
    );

    hamming_encoder u_ref (.data_i(ref_data), .codeword_o(ref_cw));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent bench-side encoder written straight from the parity equations.
    function automatic logic [6:0] tb_enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    function automatic logic [2:0] tb_syndrome(input logic [6:0] c);
        logic [2:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

    // Wait (bounded) at negedges until dut0 is ready.
    task automatic wait_ready0(input string tag);
        int k;
        k = 0;
        while (!in_ready0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Send one nibble to dut0 and check codeword plus the full serial frame.
    task automatic send_check0(input string tag, input logic [3:0] d, input logic en,
                               input logic [2:0] pos, input logic [6:0] exp_cw);
        wait_ready0(tag);
        in_valid0 = 1'b1; in_data0 = d; inj_en0 = en; inj_pos0 = pos;
        @(negedge clk);
        in_valid0 = 1'b0;
        check_eq({tag, "_cv"}, 32'(code_valid0), 32'd1);
        check_eq({tag, "_cw"}, 32'(codeword0), 32'(exp_cw));
        for (int i = 0; i < 7; i++) begin
            check_eq({tag, "_sval"}, 32'(ser_valid0), 32'd1);
            check_eq({tag, "_sout"}, 32'(ser_out0), 32'(exp_cw[i]));
            check_eq({tag, "_fs"}, 32'(frame_start0), (i == 0) ? 32'd1 : 32'd0);
            check_eq({tag, "_rdy"}, 32'(in_ready0), (i == 6) ? 32'd1 : 32'd0);
            if (i == 1) check_eq({tag, "_cv_pulse"}, 32'(code_valid0), 32'd0);
            @(negedge clk);
        end
        check_eq({tag, "_end_sval"}, 32'(ser_valid0), 32'd0);
        check_eq({tag, "_end_sout"}, 32'(ser_out0), 32'd0);
    endtask

    initial begin
        logic [6:0] exp_cw;
        logic [6:0] cw_a;
        logic [6:0] cw_1;
        logic [6:0] cw_f;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_cw", 32'(codeword0), 32'd0);
        check_eq("rst_cv", 32'(code_valid0), 32'd0);
        check_eq("rst_sval", 32'(ser_valid0), 32'd0);
        check_eq("rst_sout", 32'(ser_out0), 32'd0);
        check_eq("rst_fs", 32'(frame_start0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_rdy", 32'(in_ready0), 32'd1);
        check_eq("rst_rdy3", 32'(in_ready3), 32'd1);

        // GAP_CYCLES=3 with continuous valid: 7 shift, 3 gap, 1 idle accept.
        cw_a = 7'b1010010;
        in_valid3 = 1'b1; in_data3 = 4'hA;
        @(negedge clk);
        for (int j = 0; j < 22; j++) begin
            int m;
            m = j % 11;
            check_eq("gap3_sval", 32'(ser_valid3), (m < 7) ? 32'd1 : 32'd0);
            check_eq("gap3_rdy", 32'(in_ready3), (m == 10) ? 32'd1 : 32'd0);
            check_eq("gap3_sout", 32'(ser_out3), (m < 7) ? 32'(cw_a[m]) : 32'd0);
            check_eq("gap3_fs", 32'(frame_start3), (m == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        in_valid3 = 1'b0;

        // Hand-computed vectors.
        send_check0("d1011", 4'b1011, 1'b0, 3'd0, 7'b1010101);
        send_check0("inj3", 4'b0000, 1'b1, 3'd3, 7'b0000100);
        check_eq("inj3_syn", 32'(tb_syndrome(codeword0)), 32'd3);
        exp_cw = codeword0 ^ 7'b0000100;
        check_eq("inj3_data", 32'({exp_cw[6], exp_cw[5], exp_cw[4], exp_cw[2]}), 32'd0);
        send_check0("inj_off", 4'b0110, 1'b0, 3'd5, 7'b0110011);
        send_check0("inj7", 4'b1111, 1'b1, 3'd7, 7'b0111111);

        // Gapless back-to-back frames with in_valid held.
        cw_1 = 7'b0000111;
        cw_f = 7'b1111111;
        wait_ready0("b2b");
        in_valid0 = 1'b1; in_data0 = 4'h1; inj_en0 = 1'b0; inj_pos0 = 3'd0;
        @(negedge clk);
        in_data0 = 4'hF;
        for (int i = 0; i < 14; i++) begin
            check_eq("b2b_sval", 32'(ser_valid0), 32'd1);
            check_eq("b2b_fs", 32'(frame_start0), (i == 0 || i == 7) ? 32'd1 : 32'd0);
            check_eq("b2b_sout", 32'(ser_out0), (i < 7) ? 32'(cw_1[i]) : 32'(cw_f[i - 7]));
            if (i == 7) begin
                check_eq("b2b_cw2", 32'(codeword0), 32'(cw_f));
                in_valid0 = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("b2b_end", 32'(ser_valid0), 32'd0);

        // Reset in the middle of a frame (SHIFT cnt=3).
        wait_ready0("midrst");
        in_valid0 = 1'b1; in_data0 = 4'b1011; inj_en0 = 1'b0; inj_pos0 = 3'd0;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_pre", 32'(ser_valid0), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_sval", 32'(ser_valid0), 32'd0);
        check_eq("midrst_cw", 32'(codeword0), 32'd0);
        check_eq("midrst_sout", 32'(ser_out0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_idle", 32'(ser_valid0), 32'd0);
        check_eq("midrst_rdy", 32'(in_ready0), 32'd1);
        send_check0("post_rst", 4'b0110, 1'b0, 3'd0, 7'b0110011);

        // Exhaustive nibble x injection position sweep.
        for (int d = 0; d < 16; d++) begin
            ref_data = 4'(d);
            #1;
            check_eq("ref_enc", 32'(ref_cw), 32'(tb_enc(4'(d))));
            for (int p = 0; p < 8; p++) begin
                logic [6:0] mask;
                mask = 7'd0;
                if (p != 0) mask = 7'd1 << (p - 1);
                wait_ready0("sweep");
                in_valid0 = 1'b1; in_data0 = 4'(d); inj_en0 = 1'b1; inj_pos0 = 3'(p);
                @(negedge clk);
                in_valid0 = 1'b0;
                check_eq("sweep_cw", 32'(codeword0), 32'(tb_enc(4'(d)) ^ mask));
                check_eq("sweep_cv", 32'(code_valid0), 32'd1);
            end
        end
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
